ldpc_decoder: RTL and testbench

LDPC_DECODER -- requirements
Module: ldpc_decoder

---
 rtl/ldpc_decoder_if.sv | 27 ++
 rtl/ldpc_decoder.sv | 253 +++++++++++++++++++++++++
 tb/tb_ldpc_decoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_decoder_if.sv
// Bus bundle for the LDPC decoder: load port, readout port and frame flag.
// The master side (host/testbench) drives loads and read addresses; the
// slave side (decoder) returns hard decisions and the frame-done toggle.
interface ldpc_decoder_if #(
  parameter int K             = 6,
  parameter int ADDR_WIDTH    = 5,
  parameter int MESSAGE_WIDTH = 5
);
  logic                            en;
  logic [K*K-1:0]                  pe_select;
  logic signed [MESSAGE_WIDTH-1:0] int_in;
  logic [ADDR_WIDTH-1:0]           load_add_in;
  logic [ADDR_WIDTH-1:0]           read_add_in;
  logic [K-1:0]                    column_select;
  logic [K*K-1:0]                  dec_out_fin;
  logic                            f_id;

  modport master (
    output en, pe_select, int_in, load_add_in, read_add_in, column_select,
    input  dec_out_fin, f_id
  );

  modport slave (
    input  en, pe_select, int_in, load_add_in, read_add_in, column_select,
    output dec_out_fin, f_id
  );
endinterface

// File: rtl/ldpc_decoder.sv
// Bit-flipping style LDPC decoder on a K x K grid of processing elements.
// Each PE holds L signed posteriors. Every bit sits in one row check A(x,a)
// and one diagonal check B(y,(a-x) mod L); each decode iteration pulls every
// bit's posterior toward the opposite sign by STEP per unsatisfied check.
module ldpc_decoder #(
  parameter int L                 = 32,
  parameter int K                 = 6,
  parameter int ADDR_WIDTH        = 5,
  parameter int MESSAGE_WIDTH     = 5,
  parameter int CNU_DATA_IN_WIDTH = 6,
  parameter int MAX_ITER          = 8,
  parameter int STEP              = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ldpc_decoder_if.slave  bus
);

  localparam int NPE   = K * K;
  localparam int CW    = CNU_DATA_IN_WIDTH;
  localparam int IW    = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);
  localparam int PW    = (NPE < 2) ? 1 : $clog2(NPE);
  localparam int P_MAX = (2 ** (CW - 1)) - 1;
  localparam int P_MIN = -(2 ** (CW - 1));

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_DECODE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Posterior storage, indexed [PE p = x*K+y][address a]
  logic signed [CW-1:0] post_r     [NPE][L];
  logic signed [CW-1:0] post_upd_s [NPE][L];

  // Check parities: 1 means the check is unsatisfied
  logic fail_a_s [K][L];
  logic fail_b_s [K][L];
  logic all_ok_s;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [IW-1:0]        iter_r;
  logic                 f_id_r;

  logic                            wr_valid_s;
  logic                            wr_addr_ok_s;
  logic [PW-1:0]                   wr_pe_s;
  logic signed [MESSAGE_WIDTH-1:0] int_in_s;
  logic                            rd_addr_ok_s;
  logic [NPE-1:0]                  dec_out_s;

  logic do_write_s;
  logic do_update_s;
  logic clr_iter_s;
  logic inc_iter_s;
  logic toggle_s;

  // Hard decision: negative posterior means bit 1, zero counts as bit 0
  function automatic logic hard_bit(input logic signed [CW-1:0] p);
    return p[CW-1];
  endfunction

  // Move a posterior toward the opposite sign by u*STEP, saturating
  function automatic logic signed [CW-1:0] adjust(input logic signed [CW-1:0] p,
                                                   input logic [1:0]           u);
    int w;
    int d;
    int r;
    d = int'(u) * STEP;
    if (hard_bit(p)) begin
      w = int'(p) + d;
    end else begin
      w = int'(p) - d;
    end
    if (w > P_MAX) begin
      r = P_MAX;
    end else if (w < P_MIN) begin
      r = P_MIN;
    end else begin
      r = w;
    end
    return r[CW-1:0];
  endfunction

  assign int_in_s = bus.int_in;

  // Decode the one-hot PE select into an index and qualify the load address
  always_comb begin
    wr_pe_s      = '0;
    wr_valid_s   = $onehot(bus.pe_select);
    wr_addr_ok_s = (int'(bus.load_add_in) < L);
    for (int p = 0; p < NPE; p++) begin
      wr_pe_s = wr_pe_s | (bus.pe_select[p] ? PW'(p) : '0);
    end
  end

  // Evaluate all row (A) and diagonal (B) parity checks from the hard bits
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int a = 0; a < L; a++) begin
        fail_a_s[i][a] = 1'b0;
        fail_b_s[i][a] = 1'b0;
      end
    end
    all_ok_s = 1'b1;
    for (int x = 0; x < K; x++) begin
      for (int a = 0; a < L; a++) begin
        for (int y = 0; y < K; y++) begin
          fail_a_s[x][a] = fail_a_s[x][a] ^ hard_bit(post_r[x*K+y][a]);
        end
      end
    end
    for (int y = 0; y < K; y++) begin
      for (int a = 0; a < L; a++) begin
        for (int x = 0; x < K; x++) begin
          fail_b_s[y][a] = fail_b_s[y][a] ^ hard_bit(post_r[x*K+y][(a + x) % L]);
        end
      end
    end
    for (int i = 0; i < K; i++) begin
      for (int a = 0; a < L; a++) begin
        all_ok_s = all_ok_s & ~fail_a_s[i][a] & ~fail_b_s[i][a];
      end
    end
  end

  // Candidate posteriors for one iteration: every bit updated in parallel
  always_comb begin
    for (int x = 0; x < K; x++) begin
      for (int y = 0; y < K; y++) begin
        for (int a = 0; a < L; a++) begin
          post_upd_s[x*K+y][a] = adjust(post_r[x*K+y][a],
                                        {1'b0, fail_a_s[x][a]} +
                                        {1'b0, fail_b_s[y][(((a - x) % L) + L) % L]});
        end
      end
    end
  end

  // Next-state and control decode; the whole machine holds while en is low
  always_comb begin
    state_nxt_s = state_r;
    do_write_s  = 1'b0;
    do_update_s = 1'b0;
    clr_iter_s  = 1'b0;
    inc_iter_s  = 1'b0;
    toggle_s    = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (bus.en && wr_valid_s && wr_addr_ok_s) begin
          do_write_s = 1'b1;
          if ((wr_pe_s == PW'(NPE - 1)) && (bus.load_add_in == ADDR_WIDTH'(L - 1))) begin
            state_nxt_s = ST_DECODE;
            clr_iter_s  = 1'b1;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_DECODE: begin
        if (!bus.en) begin
          state_nxt_s = ST_DECODE;
        end else if (all_ok_s) begin
          state_nxt_s = ST_DONE;
        end else if (int'(iter_r) >= MAX_ITER) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DECODE;
          do_update_s = 1'b1;
          inc_iter_s  = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.en) begin
          state_nxt_s = ST_LOAD;
          toggle_s    = 1'b1;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_LOAD;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Iteration counter: cleared when a frame finishes loading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_r <= '0;
    end else if (clr_iter_s) begin
      iter_r <= '0;
    end else if (inc_iter_s) begin
      iter_r <= iter_r + IW'(1);
    end else begin
      iter_r <= iter_r;
    end
  end

  // Frame-done flag toggles once per completed frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_id_r <= 1'b0;
    end else if (toggle_s) begin
      f_id_r <= ~f_id_r;
    end else begin
      f_id_r <= f_id_r;
    end
  end

  // Posterior memory: sample load in LOAD, bulk update in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NPE; p++) begin
        for (int a = 0; a < L; a++) begin
          post_r[p][a] <= '0;
        end
      end
    end else if (do_write_s) begin
      post_r[wr_pe_s][bus.load_add_in] <= CW'(int_in_s);
    end else if (do_update_s) begin
      post_r <= post_upd_s;
    end
  end

  // Combinational readout of hard bits, gated per grid column
  always_comb begin
    dec_out_s    = '0;
    rd_addr_ok_s = (int'(bus.read_add_in) < L);
    for (int x = 0; x < K; x++) begin
      for (int y = 0; y < K; y++) begin
        dec_out_s[x*K+y] = bus.column_select[x] & rd_addr_ok_s &
                           hard_bit(post_r[x*K+y][bus.read_add_in]);
      end
    end
  end

  assign bus.dec_out_fin = dec_out_s;
  assign bus.f_id        = f_id_r;

endmodule

// File: tb/tb_ldpc_decoder.sv
// Directed bench for ldpc_decoder: reset state, pattern readout table,
// gated/ignored writes, frame latency and iteration cap, reset mid-decode.
// The iteration cap is set to 1 so a single strong error reaches the limit.
module tb_ldpc_decoder;

  localparam int K           = 6;
  localparam int L           = 32;
  localparam int AW          = 5;
  localparam int MW          = 5;
  localparam int NPE         = K * K;
  localparam int TB_MAX_ITER = 1;

  typedef struct {
    logic [K-1:0]   col;
    logic [AW-1:0]  addr;
    logic [NPE-1:0] exp;
  } rd_vec_t;

  logic    clk = 1'b0;
  logic    rst_n;
  int      checks;
  int      failures;
  int      lat;
  rd_vec_t tbl[$];

  always #5 clk = ~clk;

  ldpc_decoder_if #(.K(K), .ADDR_WIDTH(AW), .MESSAGE_WIDTH(MW)) bus ();

  ldpc_decoder #(
    .L(L), .K(K), .ADDR_WIDTH(AW), .MESSAGE_WIDTH(MW),
    .CNU_DATA_IN_WIDTH(6), .MAX_ITER(TB_MAX_ITER), .STEP(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_vec(input string name, input logic [NPE-1:0] act, input logic [NPE-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Readout pattern: negative on a sparse modular rule, magnitude varies with a
  function automatic logic signed [MW-1:0] pat_val(input int p, input int a);
    int m;
    m = a % 8;
    if (((p + 3 * a) % 7) == 2) begin
      return MW'(-(1 + m));
    end else begin
      return MW'(m);
    end
  endfunction

  // Expected hard bit; the unwritten trigger location keeps its reset value 0
  function automatic logic pat_bit(input int p, input int a);
    if (p == NPE - 1 && a == L - 1) begin
      return 1'b0;
    end
    return (((p + 3 * a) % 7) == 2);
  endfunction

  function automatic logic [NPE-1:0] row_bits(input int x, input int a);
    logic [NPE-1:0] r;
    r = '0;
    for (int y = 0; y < K; y++) begin
      r[x*K+y] = pat_bit(x * K + y, a);
    end
    return r;
  endfunction

  task automatic drive_write(input int p, input int a, input logic signed [MW-1:0] v);
    bus.en          = 1'b1;
    bus.pe_select   = {{(NPE-1){1'b0}}, 1'b1} << p;
    bus.load_add_in = AW'(a);
    bus.int_in      = v;
    @(posedge clk);
    #1;
  endtask

  // Full frame of +7, except PE(0,0) address 0 which gets v00
  task automatic load_frame(input logic signed [MW-1:0] v00);
    for (int p = 0; p < NPE; p++) begin
      for (int a = 0; a < L; a++) begin
        drive_write(p, a, (p == 0 && a == 0) ? v00 : 5'sd7);
      end
    end
  endtask

  // Load a frame and count en=1 edges from the last write until f_id toggles
  task automatic run_frame(input logic signed [MW-1:0] v00, input bit hold_write, output int l);
    logic old;
    old = bus.f_id;
    load_frame(v00);
    if (hold_write) begin
      bus.pe_select   = {{(NPE-1){1'b0}}, 1'b1};
      bus.load_add_in = '0;
      bus.int_in      = -5'sd1;
    end else begin
      bus.pe_select = '0;
    end
    l = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.f_id !== old) begin
        l = c;
        break;
      end
    end
    bus.pe_select = '0;
  endtask

  task automatic check_reads_zero(input string name);
    bus.column_select = '1;
    for (int a = 0; a < L; a++) begin
      bus.read_add_in = AW'(a);
      @(negedge clk);
      check_vec($sformatf("%s[a=%0d]", name, a), bus.dec_out_fin, '0);
    end
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    rst_n             = 1'b0;
    bus.en            = 1'b0;
    bus.pe_select     = '0;
    bus.int_in        = '0;
    bus.load_add_in   = '0;
    bus.read_add_in   = '0;
    bus.column_select = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      bus.read_add_in = AW'(i * 15);
      @(negedge clk);
      check_vec("reset_read", bus.dec_out_fin, '0);
    end
    check_int("reset_fid", int'(bus.f_id), 0);

    // Load a pattern without the trigger location, so no decode starts
    for (int p = 0; p < NPE; p++) begin
      for (int a = 0; a < L; a++) begin
        if (!(p == NPE - 1 && a == L - 1)) begin
          drive_write(p, a, pat_val(p, a));
        end
      end
    end
    bus.pe_select = '0;

    // Readout table: one-hot column gates over every address, plus all/none
    for (int x = 0; x < K; x++) begin
      for (int a = 0; a < L; a++) begin
        tbl.push_back('{col: K'(1 << x), addr: AW'(a), exp: row_bits(x, a)});
      end
    end
    for (int a = 0; a < L; a += 31) begin
      tbl.push_back('{col: '0, addr: AW'(a), exp: '0});
      tbl.push_back('{col: '1, addr: AW'(a),
                      exp: row_bits(0, a) | row_bits(1, a) | row_bits(2, a) |
                           row_bits(3, a) | row_bits(4, a) | row_bits(5, a)});
    end
    for (int i = 0; i < tbl.size(); i++) begin
      bus.column_select = tbl[i].col;
      bus.read_add_in   = tbl[i].addr;
      @(negedge clk);
      check_vec($sformatf("readout[%0d]", i), bus.dec_out_fin, tbl[i].exp);
    end

    // Write with en=0 is ignored
    bus.en          = 1'b0;
    bus.pe_select   = {{(NPE-1){1'b0}}, 1'b1};
    bus.load_add_in = '0;
    bus.int_in      = -5'sd5;
    @(posedge clk);
    #1;
    bus.en            = 1'b1;
    bus.pe_select     = '0;
    bus.column_select = 6'b000001;
    bus.read_add_in   = '0;
    @(negedge clk);
    check_vec("en0_write", bus.dec_out_fin, row_bits(0, 0));

    // Enabled write lands: PE(0,1) address 2 becomes negative
    drive_write(1, 2, -5'sd3);
    bus.pe_select   = '0;
    bus.read_add_in = 5'd2;
    @(negedge clk);
    check_vec("en1_write", bus.dec_out_fin, row_bits(0, 2) | {{(NPE-2){1'b0}}, 2'b10});

    // Two-hot select is ignored
    bus.pe_select   = {{(NPE-2){1'b0}}, 2'b11};
    bus.load_add_in = 5'd3;
    bus.int_in      = -5'sd8;
    @(posedge clk);
    #1;
    bus.pe_select   = '0;
    bus.read_add_in = 5'd3;
    @(negedge clk);
    check_vec("twohot_write", bus.dec_out_fin, row_bits(0, 3));

    // Clean frame: checks pass at once
    run_frame(5'sd7, 1'b0, lat);
    check_int("lat_clean", lat, 2);
    check_int("fid_clean", int'(bus.f_id), 1);
    check_reads_zero("clean_read");

    // Writes held during DECODE/DONE are ignored
    run_frame(5'sd7, 1'b1, lat);
    check_int("lat_hold", lat, 2);
    check_int("fid_hold", int'(bus.f_id), 0);
    check_reads_zero("hold_read");

    // Strong error -16: one update to -8, then the iteration cap ends the frame
    run_frame(5'sb10000, 1'b0, lat);
    check_int("lat_cap", lat, TB_MAX_ITER + 2);
    check_int("fid_cap", int'(bus.f_id), 1);
    bus.column_select = '1;
    bus.read_add_in   = '0;
    @(negedge clk);
    check_vec("cap_read_a0", bus.dec_out_fin, {{(NPE-1){1'b0}}, 1'b1});
    bus.read_add_in = 5'd1;
    @(negedge clk);
    check_vec("cap_read_a1", bus.dec_out_fin, '0);

    // Reset during DECODE aborts the frame
    load_frame(5'sb10000);
    bus.pe_select = '0;
    @(posedge clk);
    #1;
    bus.read_add_in = '0;
    #2;
    check_vec("pre_reset_read", bus.dec_out_fin, {{(NPE-1){1'b0}}, 1'b1});
    rst_n = 1'b0;
    #1;
    check_vec("reset_mid_read", bus.dec_out_fin, '0);
    check_int("reset_mid_fid", int'(bus.f_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_int("no_toggle_after_abort", int'(bus.f_id), 0);

    // Fresh frame with a weak error: one update, then checks pass
    run_frame(-5'sd1, 1'b0, lat);
    check_int("lat_weak", lat, 3);
    check_int("fid_weak", int'(bus.f_id), 1);
    check_reads_zero("weak_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
